// File: rtl/pwconv_point_acc.sv
// Pointwise-convolution point accumulator: lane-wise multiply, pipelined adder tree,
// then bias-seeded accumulation across beats with optional ReLU on the final result.
module pwconv_point_acc #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANES  = 32,
    parameter int unsigned ACC_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic [LANES*DATA_W-1:0] data_in,
    input  logic [LANES*DATA_W-1:0] weight,
    input  logic signed [ACC_W-1:0] bias,
    input  logic                    relu_en,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] data_out,
    output logic                    busy
);
    localparam int unsigned LOG = $clog2(LANES);
    localparam int unsigned SW  = 2 * DATA_W + LOG;
    localparam int unsigned NST = LOG + 1;

    // Every tree level is held at the final sum width; sign extension keeps values exact.
    logic signed [SW-1:0]    lvl_q  [NST][LANES];
    logic signed [SW-1:0]    prod   [LANES];
    logic [NST-1:0]          vld_q, first_q, last_q, relu_q;
    logic signed [ACC_W-1:0] bias_q [NST];
    logic signed [ACC_W-1:0] acc_q, acc_d, sum_ext, res_d;
    logic                    open_q;

    always_comb begin
        for (int j = 0; j < int'(LANES); j++) begin
            prod[j] = SW'((2 * DATA_W)'($signed(data_in[(LANES-1-j)*DATA_W +: DATA_W]))
                        * (2 * DATA_W)'($signed(weight[(LANES-1-j)*DATA_W +: DATA_W])));
        end
    end

    always_comb begin
        sum_ext = ACC_W'(lvl_q[LOG][0]);
        acc_d   = first_q[LOG] ? bias_q[LOG] + sum_ext : acc_q + sum_ext;
        res_d   = (relu_q[LOG] && acc_d[ACC_W-1]) ? '0 : acc_d;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int l = 0; l < int'(NST); l++) begin
                for (int j = 0; j < int'(LANES); j++) begin
                    lvl_q[l][j] <= '0;
                end
                bias_q[l] <= '0;
            end
            vld_q     <= '0;
            first_q   <= '0;
            last_q    <= '0;
            relu_q    <= '0;
            acc_q     <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            open_q    <= 1'b0;
        end else if (en) begin
            vld_q   <= {vld_q[NST-2:0], in_valid};
            first_q <= {first_q[NST-2:0], in_first};
            last_q  <= {last_q[NST-2:0], in_last};
            relu_q  <= {relu_q[NST-2:0], relu_en};
            bias_q[0] <= bias;
            for (int j = 0; j < int'(LANES); j++) begin
                lvl_q[0][j] <= prod[j];
            end
            for (int l = 1; l < int'(NST); l++) begin
                bias_q[l] <= bias_q[l-1];
                for (int j = 0; j < int'(LANES >> l); j++) begin
                    lvl_q[l][j] <= lvl_q[l-1][2*j] + lvl_q[l-1][2*j+1];
                end
            end

            // A finished point leaves acc at 0 so an unflagged stray beat starts clean.
            if (vld_q[LOG]) begin
                acc_q <= last_q[LOG] ? '0 : acc_d;
                if (last_q[LOG]) begin
                    data_out <= res_d;
                end
            end
            out_valid <= vld_q[LOG] && last_q[LOG];

            // A newly opened point outranks the previous point closing in the same cycle.
            if (in_valid && in_first && !in_last) begin
                open_q <= 1'b1;
            end else if (vld_q[LOG] && last_q[LOG]) begin
                open_q <= 1'b0;
            end
        end
    end

    assign busy = (|vld_q) | open_q;

endmodule

// File: tb/tb_pwconv_point_acc.sv
// Directed self-checking bench for pwconv_point_acc at DATA_W=8, LANES=32, ACC_W=32.
module tb_pwconv_point_acc;
    localparam int DATA_W = 8;
    localparam int LANES  = 32;
    localparam int ACC_W  = 32;
    localparam int LAT    = 7;

    logic                    clk = 1'b0;
    logic                    rst_b, en, in_valid, in_first, in_last, relu_en;
    logic [LANES*DATA_W-1:0] data_in, weight;
    logic signed [ACC_W-1:0] bias, data_out;
    logic                    out_valid, busy;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic        en_at_edge = 1'b0;
    logic [31:0] out_data [$];
    int          out_cyc  [$];
    int          t0;

    pwconv_point_acc #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ACC_W  (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .en        (en),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .data_in   (data_in),
        .weight    (weight),
        .bias      (bias),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .data_out  (data_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        en_at_edge <= en;
    end

    // One record per en-cycle in which a result is presented.
    always @(negedge clk) begin
        if (out_valid && en_at_edge) begin
            out_data.push_back(data_out);
            out_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic beat(input logic f, input logic l, input logic [7:0] d, input logic [7:0] w,
                        input logic [31:0] b, input logic r);
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        data_in  = {LANES{d}};
        weight   = {LANES{w}};
        bias     = b;
        relu_en  = r;
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input int n, input int budget);
        int k = 0;
        while (out_data.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic clear_log();
        out_data.delete();
        out_cyc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b = 1'b0; en = 1'b1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; relu_en = 1'b0;
        data_in = '0; weight = '0; bias = '0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_data_out", data_out, 32'd0);
        rst_b = 1'b1;
        idle(2);

        // Single-beat point: 32 * (1*2) + 5
        clear_log();
        t0 = cyc;
        beat(1'b1, 1'b1, 8'd1, 8'd2, 32'd5, 1'b0);
        wait_out(1, 20);
        idle(4);
        check("t1_count", out_data.size(), 32'd1);
        if (out_data.size() >= 1) begin
            check("t1_data", out_data[0], 32'd69);
            check("t1_latency", out_cyc[0] - t0, LAT);
        end

        // Three-beat point with a long gap: open flag must keep busy high
        clear_log();
        beat(1'b1, 1'b0, 8'd1, 8'd1, 32'hFFFF_FFF6, 1'b1);
        idle(10);
        check("t2_open_busy", 32'(busy), 32'd1);
        beat(1'b0, 1'b0, 8'd2, 8'd1, 32'd12345, 1'b1);
        beat(1'b0, 1'b1, 8'd3, 8'd1, 32'd777, 1'b0);
        wait_out(1, 20);
        idle(4);
        check("t2_count", out_data.size(), 32'd1);
        if (out_data.size() >= 1) check("t2_data", out_data[0], 32'd182);
        check("t2_idle_busy", 32'(busy), 32'd0);

        // ReLU on then off, back to back: 32 * (-1*3) = -96
        clear_log();
        beat(1'b1, 1'b1, 8'hFF, 8'd3, 32'd0, 1'b1);
        beat(1'b1, 1'b1, 8'hFF, 8'd3, 32'd0, 1'b0);
        wait_out(2, 20);
        idle(4);
        check("t3_count", out_data.size(), 32'd2);
        if (out_data.size() >= 2) begin
            check("t3_relu_on", out_data[0], 32'd0);
            check("t3_relu_off", out_data[1], 32'hFFFF_FFA0);
            check("t3_spacing", out_cyc[1] - out_cyc[0], 32'd1);
        end

        // Extremes wrap past the positive limit
        clear_log();
        beat(1'b1, 1'b0, 8'h80, 8'h80, 32'h7FFF_FFF0, 1'b0);
        beat(1'b0, 1'b1, 8'h80, 8'h80, 32'd0, 1'b0);
        wait_out(1, 20);
        idle(4);
        check("t4_count", out_data.size(), 32'd1);
        if (out_data.size() >= 1) begin
            check("t4_data", out_data[0], 32'h800F_FFF0);
            check("t4_sign", 32'(out_data[0][31]), 32'd1);
        end

        // Stream with a 3-cycle stall; the beat offered during the stall must be ignored
        clear_log();
        t0 = cyc;
        for (int i = 1; i <= 3; i++) beat(1'b1, 1'b1, 8'd0, 8'd0, 32'(i), 1'b0);
        en = 1'b0;
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; bias = 32'd99;
        repeat (3) @(negedge clk);
        en = 1'b1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        for (int i = 4; i <= 6; i++) beat(1'b1, 1'b1, 8'd0, 8'd0, 32'(i), 1'b0);
        wait_out(6, 40);
        idle(4);
        check("t5_count", out_data.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (out_data.size() > i) begin
                check($sformatf("t5_data%0d", i + 1), out_data[i], 32'(i + 1));
                check($sformatf("t5_cycle%0d", i + 1), out_cyc[i] - t0, 32'(LAT + 3 + i));
            end
        end

        // Reset after the 2nd of 4 beats, then a fresh point
        clear_log();
        beat(1'b1, 1'b0, 8'd1, 8'd1, 32'd100, 1'b0);
        beat(1'b0, 1'b0, 8'd1, 8'd1, 32'd0, 1'b0);
        rst_b = 1'b0;
        #1;
        check("t6_rst_out_valid", 32'(out_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_data_out", data_out, 32'd0);
        idle(2);
        rst_b = 1'b1;
        idle(1);
        clear_log();
        t0 = cyc;
        beat(1'b1, 1'b1, 8'd0, 8'd0, 32'd7, 1'b0);
        wait_out(1, 20);
        idle(10);
        check("t6_count", out_data.size(), 32'd1);
        if (out_data.size() >= 1) begin
            check("t6_data", out_data[0], 32'd7);
            check("t6_latency", out_cyc[0] - t0, LAT);
        end
        check("end_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
